// File: rtl/parking_gate_controller.sv
// parking_gate_controller
//   Occupancy tracker and barrier sequencer for a single parking lot with an
//   entry barrier and an exit barrier. Each barrier has its own handshake
//   FSM. A request rising edge opens the barrier. The pass beam commits the
//   vehicle, which changes the count. If no vehicle breaks the beam within
//   GATE_TIMEOUT cycles, the barrier closes and the count is left unchanged.
//   RESERVED spots are available only to permit holders.
//
// Parameters
//   MAX_PARKING   lot capacity (1 .. 2**CNT_W-1)
//   CNT_W         width of the count outputs
//   RESERVED      spots held back for permit holders (0 .. MAX_PARKING)
//   GATE_TIMEOUT  cycles a barrier stays open without a pass (>= 2)
//
// Ports
//   CLK, RESET                rising-edge clock, async active-high reset
//   ENTRY_req / EXIT_req      vehicle on entry / exit loop (level)
//   ENTRY_permit              permit holder, sampled with ENTRY_req rise
//   ENTRY_pass / EXIT_pass    pass beam broken (level)
//   ENTRY_gate_open           entry barrier open command (registered)
//   EXIT_gate_open            exit barrier open command (registered)
//   ENTRY_denied              one-cycle pulse, entry refused for lack of room
//   TIMEOUT_err               one-cycle pulse, either barrier timed out
//   Parking_count             occupied spots
//   Available_spots           free spots; an open entry barrier counts as taken
//   FULL / EMPTY              Parking_count == MAX_PARKING / == 0
//
// Optional build macro
//   PARK_STATS_EN  adds Total_entries[15:0] (saturating count of entry
//                  commits) and Denied_count[7:0] (saturating count of
//                  ENTRY_denied pulses). Both are cleared only by RESET.

module parking_gate_controller #(
  parameter int MAX_PARKING  = 8,
  parameter int CNT_W        = 4,
  parameter int RESERVED     = 0,
  parameter int GATE_TIMEOUT = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENTRY_req,
  input  logic             ENTRY_permit,
  input  logic             ENTRY_pass,
  input  logic             EXIT_req,
  input  logic             EXIT_pass,
  output logic             ENTRY_gate_open,
  output logic             EXIT_gate_open,
  output logic             ENTRY_denied,
  output logic             TIMEOUT_err,
  output logic [CNT_W-1:0] Parking_count,
  output logic [CNT_W-1:0] Available_spots,
  output logic             FULL,
  output logic             EMPTY
`ifdef PARK_STATS_EN
  ,
  output logic [15:0]      Total_entries,
  output logic [7:0]       Denied_count
`endif
);

  localparam int TMR_W = (GATE_TIMEOUT > 2) ? $clog2(GATE_TIMEOUT) : 1;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_PARKING);
  localparam logic [CNT_W-1:0] LIM_PUB  = CNT_W'(MAX_PARKING - RESERVED);

  typedef enum logic [1:0] {
    G_IDLE = 2'd0,
    G_OPEN = 2'd1,
    G_PASS = 2'd2
  } gate_state_t;

  gate_state_t      entry_state, entry_state_nxt;
  gate_state_t      exit_state,  exit_state_nxt;
  logic [TMR_W-1:0] entry_timer, entry_timer_nxt;
  logic [TMR_W-1:0] exit_timer,  exit_timer_nxt;
  logic             entry_req_q, exit_req_q;
  logic             entry_rise,  exit_rise;
  logic             entry_room;
  logic             entry_commit, exit_commit;
  logic             entry_deny;
  logic             entry_tout, exit_tout;
  logic [CNT_W-1:0] count_r, count_nxt;
  logic [CNT_W:0]   avail_full;

  assign entry_rise = ENTRY_req & ~entry_req_q;
  assign exit_rise  = EXIT_req  & ~exit_req_q;

  // A non-permit vehicle must leave RESERVED spots free.
  assign entry_room = ENTRY_permit ? (count_r < MAX_C) : (count_r < LIM_PUB);

  // Entry barrier next-state
  always_comb begin
    entry_state_nxt = entry_state;
    entry_timer_nxt = '0;
    entry_commit    = 1'b0;
    entry_deny      = 1'b0;
    entry_tout      = 1'b0;
    case (entry_state)
      G_IDLE: begin
        if (entry_rise) begin
          if (entry_room) entry_state_nxt = G_OPEN;
          else            entry_deny      = 1'b1;
        end
      end
      G_OPEN: begin
        if (ENTRY_pass) begin
          entry_state_nxt = G_PASS;
          entry_commit    = 1'b1;
        end else if (entry_timer == TMR_LAST) begin
          entry_state_nxt = G_IDLE;
          entry_tout      = 1'b1;
        end else begin
          entry_timer_nxt = entry_timer + TMR_W'(1);
        end
      end
      G_PASS: begin
        if (!ENTRY_pass) entry_state_nxt = G_IDLE;
      end
      default: entry_state_nxt = G_IDLE;
    endcase
  end

  // Exit barrier next-state (always granted)
  always_comb begin
    exit_state_nxt = exit_state;
    exit_timer_nxt = '0;
    exit_commit    = 1'b0;
    exit_tout      = 1'b0;
    case (exit_state)
      G_IDLE: begin
        if (exit_rise) exit_state_nxt = G_OPEN;
      end
      G_OPEN: begin
        if (EXIT_pass) begin
          exit_state_nxt = G_PASS;
          exit_commit    = 1'b1;
        end else if (exit_timer == TMR_LAST) begin
          exit_state_nxt = G_IDLE;
          exit_tout      = 1'b1;
        end else begin
          exit_timer_nxt = exit_timer + TMR_W'(1);
        end
      end
      G_PASS: begin
        if (!EXIT_pass) exit_state_nxt = G_IDLE;
      end
      default: exit_state_nxt = G_IDLE;
    endcase
  end

  // Occupancy update. Simultaneous commits cancel. Both directions saturate.
  always_comb begin
    count_nxt = count_r;
    if (entry_commit && !exit_commit) begin
      if (count_r != MAX_C) count_nxt = count_r + CNT_W'(1);
    end else if (exit_commit && !entry_commit) begin
      if (count_r != '0) count_nxt = count_r - CNT_W'(1);
    end
  end

  // The gate_open flops load from the next state. They change on the same
  // edge as the state register, so they behave as a registered copy of
  // (state != G_IDLE) without an extra cycle of latency.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      entry_state     <= G_IDLE;
      exit_state      <= G_IDLE;
      entry_timer     <= '0;
      exit_timer      <= '0;
      entry_req_q     <= 1'b0;
      exit_req_q      <= 1'b0;
      ENTRY_gate_open <= 1'b0;
      EXIT_gate_open  <= 1'b0;
      ENTRY_denied    <= 1'b0;
      TIMEOUT_err     <= 1'b0;
      count_r         <= '0;
    end else begin
      entry_state     <= entry_state_nxt;
      exit_state      <= exit_state_nxt;
      entry_timer     <= entry_timer_nxt;
      exit_timer      <= exit_timer_nxt;
      entry_req_q     <= ENTRY_req;
      exit_req_q      <= EXIT_req;
      ENTRY_gate_open <= (entry_state_nxt != G_IDLE);
      EXIT_gate_open  <= (exit_state_nxt != G_IDLE);
      ENTRY_denied    <= entry_deny;
      TIMEOUT_err     <= entry_tout | exit_tout;
      count_r         <= count_nxt;
    end
  end

`ifdef PARK_STATS_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Total_entries <= '0;
      Denied_count  <= '0;
    end else begin
      if (entry_commit && (Total_entries != '1))
        Total_entries <= Total_entries + 16'd1;
      if (entry_deny && (Denied_count != '1))
        Denied_count <= Denied_count + 8'd1;
    end
  end
`endif

  // An entry barrier that is open but not yet passed holds one spot. The
  // widened subtraction is clamped so the output never goes negative.
  assign avail_full = {1'b0, MAX_C} - {1'b0, count_r}
                    - {{CNT_W{1'b0}}, (entry_state == G_OPEN)};

  assign Available_spots = avail_full[CNT_W] ? '0 : avail_full[CNT_W-1:0];
  assign Parking_count   = count_r;
  assign FULL            = (count_r == MAX_C);
  assign EMPTY           = (count_r == '0);

endmodule

// File: tb/tb_parking_gate_controller.sv
module tb_parking_gate_controller;

  localparam int MAXP = 8;
  localparam int RES  = 2;
  localparam int TOUT = 16;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       ENTRY_req, ENTRY_permit, ENTRY_pass, EXIT_req, EXIT_pass;
  logic       ENTRY_gate_open, EXIT_gate_open, ENTRY_denied, TIMEOUT_err;
  logic [3:0] Parking_count, Available_spots;
  logic       FULL, EMPTY;
`ifdef PARK_STATS_EN
  logic [15:0] Total_entries;
  logic [7:0]  Denied_count;
`endif

  parking_gate_controller #(
    .MAX_PARKING (MAXP),
    .CNT_W       (4),
    .RESERVED    (RES),
    .GATE_TIMEOUT(TOUT)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .ENTRY_req      (ENTRY_req),
    .ENTRY_permit   (ENTRY_permit),
    .ENTRY_pass     (ENTRY_pass),
    .EXIT_req       (EXIT_req),
    .EXIT_pass      (EXIT_pass),
    .ENTRY_gate_open(ENTRY_gate_open),
    .EXIT_gate_open (EXIT_gate_open),
    .ENTRY_denied   (ENTRY_denied),
    .TIMEOUT_err    (TIMEOUT_err),
    .Parking_count  (Parking_count),
    .Available_spots(Available_spots),
    .FULL           (FULL),
    .EMPTY          (EMPTY)
`ifdef PARK_STATS_EN
    ,
    .Total_entries  (Total_entries),
    .Denied_count   (Denied_count)
`endif
  );

  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: occupancy as a plain integer, each barrier described
  // by "is it up", "is a car in the beam" and "cycles spent waiting".
  int m_count;
  bit e_up, e_beam, x_up, x_beam;
  int e_wait, x_wait;
  bit e_prev, x_prev;
  bit m_denied, m_tout;
  int m_total, m_dcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    e_up = 0; e_beam = 0; x_up = 0; x_beam = 0;
    e_wait = 0; x_wait = 0;
    e_prev = 0; x_prev = 0;
    m_denied = 0; m_tout = 0;
    m_total = 0; m_dcnt = 0;
  endtask

  task automatic check_all(input string w);
    int avail;
    avail = MAXP - m_count - ((e_up && !e_beam) ? 1 : 0);
    if (avail < 0) avail = 0;
    check({w, ".entry_open"}, 32'(ENTRY_gate_open), 32'(e_up));
    check({w, ".exit_open"},  32'(EXIT_gate_open),  32'(x_up));
    check({w, ".denied"},     32'(ENTRY_denied),    32'(m_denied));
    check({w, ".timeout"},    32'(TIMEOUT_err),     32'(m_tout));
    check({w, ".count"},      32'(Parking_count),   32'(m_count));
    check({w, ".avail"},      32'(Available_spots), 32'(avail));
    check({w, ".full"},       32'(FULL),            32'(m_count == MAXP));
    check({w, ".empty"},      32'(EMPTY),           32'(m_count == 0));
`ifdef PARK_STATS_EN
    check({w, ".total"},      32'(Total_entries),   32'(m_total));
    check({w, ".dcnt"},       32'(Denied_count),    32'(m_dcnt));
`endif
  endtask

  // Apply one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input bit er, input bit ep, input bit es, input bit xr, input bit xs);
    bit e_rise, x_rise, ce, cx;
    int limit;
    ENTRY_req = er; ENTRY_permit = ep; ENTRY_pass = es;
    EXIT_req = xr;  EXIT_pass = xs;
    e_rise = er && !e_prev;
    x_rise = xr && !x_prev;
    e_prev = er; x_prev = xr;
    ce = 0; cx = 0; m_denied = 0; m_tout = 0;
    if (!e_up) begin
      if (e_rise) begin
        limit = ep ? MAXP : MAXP - RES;
        if (m_count < limit) begin e_up = 1; e_beam = 0; e_wait = 0; end
        else m_denied = 1;
      end
    end else if (!e_beam) begin
      if (es) begin e_beam = 1; ce = 1; end
      else if (e_wait == TOUT - 1) begin e_up = 0; m_tout = 1; end
      else e_wait++;
    end else if (!es) begin
      e_up = 0; e_beam = 0;
    end
    if (!x_up) begin
      if (x_rise) begin x_up = 1; x_beam = 0; x_wait = 0; end
    end else if (!x_beam) begin
      if (xs) begin x_beam = 1; cx = 1; end
      else if (x_wait == TOUT - 1) begin x_up = 0; m_tout = 1; end
      else x_wait++;
    end else if (!xs) begin
      x_up = 0; x_beam = 0;
    end
    m_count = m_count + int'(ce) - int'(cx);
    if (m_count < 0) m_count = 0;
    if (m_count > MAXP) m_count = MAXP;
    if (ce && m_total < 65535) m_total++;
    if (m_denied && m_dcnt < 255) m_dcnt++;
    @(posedge CLK);
    #1;
    check_all("step");
  endtask

  task automatic do_entry(input bit p);
    step(1, p, 0, 0, 0);
    step(1, p, 1, 0, 0);
    step(1, p, 0, 0, 0);
    step(0, p, 0, 0, 0);
  endtask

  task automatic do_exit();
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    bit er, xr;
    ENTRY_req = 0; ENTRY_permit = 0; ENTRY_pass = 0; EXIT_req = 0; EXIT_pass = 0;
    RESET = 1'b1;
    model_reset();
    #2;
    check("rst.count", 32'(Parking_count), 32'd0);
    check("rst.avail", 32'(Available_spots), 32'(MAXP));
    check("rst.full", 32'(FULL), 32'd0);
    check("rst.empty", 32'(EMPTY), 32'd1);
    check("rst.gates", {30'd0, ENTRY_gate_open, EXIT_gate_open}, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    // Basic entry: pass 3 cycles after the rise, held 2 cycles
    step(1, 0, 0, 0, 0);
    check("t1.open_after_rise", 32'(ENTRY_gate_open), 32'd1);
    check("t1.avail_open", 32'(Available_spots), 32'd7);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    check("t1.count_commit", 32'(Parking_count), 32'd1);
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    check("t1.closed", 32'(ENTRY_gate_open), 32'd0);
    step(0, 0, 0, 0, 0);

    // Fill to the reserved threshold, then probe permit logic
    repeat (5) do_entry(0);
    check("t2.count6", 32'(Parking_count), 32'd6);
    step(1, 0, 0, 0, 0);
    check("t2.denied", 32'(ENTRY_denied), 32'd1);
    check("t2.gate_closed", 32'(ENTRY_gate_open), 32'd0);
    step(0, 0, 0, 0, 0);
    check("t2.denied_pulse_end", 32'(ENTRY_denied), 32'd0);
    do_entry(1);
    check("t2.permit_count7", 32'(Parking_count), 32'd7);
    do_entry(1);
    check("t2.full", 32'(FULL), 32'd1);
    step(1, 1, 0, 0, 0);
    check("t2.denied_full", 32'(ENTRY_denied), 32'd1);
    step(0, 0, 0, 0, 0);

    // Down to 3, then simultaneous commits
    repeat (5) do_exit();
    step(1, 0, 0, 1, 0);
    step(1, 0, 1, 1, 1);
    check("t3.count_same", 32'(Parking_count), 32'd3);
    check("t3.full", 32'(FULL), 32'd0);
    check("t3.empty", 32'(EMPTY), 32'd0);
    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    // Entry timeout
    step(1, 0, 0, 0, 0);
    repeat (TOUT - 1) step(1, 0, 0, 0, 0);
    check("t4.still_open", 32'(ENTRY_gate_open), 32'd1);
    step(1, 0, 0, 0, 0);
    check("t4.timeout", 32'(TIMEOUT_err), 32'd1);
    check("t4.gate_closed", 32'(ENTRY_gate_open), 32'd0);
    check("t4.count", 32'(Parking_count), 32'd3);
    check("t4.avail", 32'(Available_spots), 32'd5);
    step(0, 0, 0, 0, 0);

    // Drain, then exit at zero
    repeat (3) do_exit();
    do_exit();
    check("t5.count_zero", 32'(Parking_count), 32'd0);
    check("t5.empty", 32'(EMPTY), 32'd1);

    // Randomized traffic
    er = 0; xr = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) er = ~er;
      if ($urandom_range(3) == 0) xr = ~xr;
      step(er, 1'($urandom_range(1)), 1'($urandom_range(1)),
           xr, 1'($urandom_range(1)));
    end

    // Settle, then reset while the entry barrier is open
    repeat (TOUT + 2) step(0, 0, 0, 0, 0);
    do_exit();
    step(1, 1, 0, 0, 0);
    check("t6.open", 32'(ENTRY_gate_open), 32'd1);
    #2;
    RESET = 1'b1;
    #1;
    check("t6.gate_async", 32'(ENTRY_gate_open), 32'd0);
    check("t6.count", 32'(Parking_count), 32'd0);
    check("t6.avail", 32'(Available_spots), 32'(MAXP));
`ifdef PARK_STATS_EN
    check("t6.total", 32'(Total_entries), 32'd0);
`endif
    model_reset();
    ENTRY_req = 0; ENTRY_permit = 0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    do_entry(0);
    check("t6.after_reset_count", 32'(Parking_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/parking_gate_controller.md
Name: parking_gate_controller

Overview:
- Parametrised successor to the single-lot occupancy counter. Tracks occupancy up to MAX_PARKING, reserves RESERVED spots for permit holders, and drives one entry barrier and one exit barrier.
- Each barrier has its own handshake FSM with a pass-beam commit and an open-timeout.
- Sits between the lot's loop/beam sensors and the barrier actuators and display. All sensor inputs are already synchronous to CLK.

Parameters:
- MAX_PARKING, 8, lot capacity (1..2**CNT_W-1).
- CNT_W, 4, width of the count outputs; must hold MAX_PARKING.
- RESERVED, 0, spots usable only by permit holders (0..MAX_PARKING).
- GATE_TIMEOUT, 16, cycles a barrier waits in OPEN for the pass beam before closing (>=2).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ENTRY_req  in  1  vehicle present on the entry loop (level).
- ENTRY_permit  in  1  permit holder at entry; sampled with the ENTRY_req rising edge.
- ENTRY_pass  in  1  entry pass-beam broken (level).
- EXIT_req  in  1  vehicle present on the exit loop (level).
- EXIT_pass  in  1  exit pass-beam broken (level).
- ENTRY_gate_open  out  1  entry barrier open command.
- EXIT_gate_open  out  1  exit barrier open command.
- ENTRY_denied  out  1  one-cycle pulse: entry refused for lack of space.
- TIMEOUT_err  out  1  one-cycle pulse: a barrier timed out; bit set by either gate.
- Parking_count  out  CNT_W  occupied spots.
- Available_spots  out  CNT_W  free spots, with an open entry gate counted as taken.
- FULL  out  1  Parking_count == MAX_PARKING.
- EMPTY  out  1  Parking_count == 0.

Behaviour:
- Reset (async): Parking_count=0, Available_spots=MAX_PARKING, FULL=0, EMPTY=1, both gate_open=0, ENTRY_denied=0, TIMEOUT_err=0, both FSMs in G_IDLE, timers=0, edge registers=0.
- Edge detection: req_rise = req & ~req_q, where req_q is registered every cycle. Entry and exit each have their own.
- Per-gate FSM states:
  - G_IDLE: gate closed.
  - G_OPEN: gate open, waiting for the beam; timer increments every cycle.
  - G_PASS: gate open, vehicle in the beam.
- Entry FSM transitions:
  - G_IDLE & req_rise & room -> G_OPEN, timer cleared.
  - room = Parking_count < MAX_PARKING - (ENTRY_permit ? 0 : RESERVED).
  - G_IDLE & req_rise & !room -> stay in G_IDLE; ENTRY_denied=1 for exactly the next cycle.
- Exit FSM transitions:
  - G_IDLE & req_rise -> G_OPEN. Always granted.
- Common transitions (both gates):
  - G_OPEN & pass -> G_PASS. This transition is the commit: entry count+1 or exit count-1.
  - G_OPEN & !pass & timer==GATE_TIMEOUT-1 -> G_IDLE. TIMEOUT_err=1 for one cycle. No count change.
  - pass takes priority over timeout in the same cycle.
  - G_PASS & !pass -> G_IDLE.
  - req_rise while not in G_IDLE is ignored; it is not queued.
- Outputs:
  - gate_open = (state != G_IDLE), registered. It asserts the cycle after the req_rise sample edge.
  - Parking_count updates on the clock edge of the commit transition.
  - Available_spots = MAX_PARKING - Parking_count - (entry_state==G_OPEN); combinational, never negative.
  - FULL and EMPTY are combinational from Parking_count.
- Simultaneous entry and exit commits in the same cycle: net count unchanged.
- Exit commit at count 0: count saturates at 0, no wrap.
- Entry commit at MAX_PARKING cannot occur because the room check holds a slot. The count also saturates defensively.
- Reset mid-operation: barriers close immediately and any pending commit is lost.

Optional Feature:
- Macro: PARK_STATS_EN.
- Defined: adds output Total_entries [15:0], reset to 0. It increments on each entry commit, saturates at 16'hFFFF, and is cleared only by RESET. It also adds output Denied_count [7:0], which increments on each ENTRY_denied pulse and saturates at 8'hFF.
- Undefined: both ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Reset, then ENTRY_req rise with ENTRY_pass asserted 3 cycles later and released 2 cycles after that:
  - gate_open=1 the cycle after the rise.
  - Available_spots=7 while in G_OPEN.
  - Parking_count=1 after the commit.
  - gate_open=0 after pass releases.
- MAX_PARKING=8, RESERVED=2, count=6:
  - Non-permit ENTRY_req rise -> ENTRY_denied pulse, gate stays closed.
  - Permit ENTRY_req rise -> gate opens, count reaches 7 after pass.
- ENTRY_req rise with no pass for GATE_TIMEOUT cycles:
  - TIMEOUT_err pulse, gate closes.
  - Parking_count unchanged, Available_spots restored.
- count=3, entry and exit pass commits on the same cycle -> Parking_count stays 3, FULL=0, EMPTY=0.
- count=0, exit cycle completes -> Parking_count=0, EMPTY=1, no wrap to 15.
- RESET asserted while the entry gate is in G_OPEN:
  - ENTRY_gate_open=0 asynchronously.
  - Parking_count=0, Available_spots=MAX_PARKING.
  - With PARK_STATS_EN, Total_entries=0.
